// File: rtl/instr_fetch_mem.sv
// Byte-addressed big-endian instruction memory with a registered 1-cycle fetch port,
// decode-stall hold, MIPS field slicing, fault flagging and a byte-wide program-load port.
module instr_fetch_mem #(
   parameter int unsigned DEPTH_BYTES = 128,
   parameter int unsigned ADDR_W      = 32,
   parameter string       INIT_FILE   = ""
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_req_i,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              stall_i,
   input  logic              ld_en_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [7:0]        ld_data_i,
   output logic              inst_valid_o,
   output logic [31:0]       instr_o,
   output logic [5:0]        op_o,
   output logic [4:0]        rs_o,
   output logic [4:0]        rt_o,
   output logic [4:0]        rd_o,
   output logic [4:0]        shamt_o,
   output logic [5:0]        funct_o,
   output logic [15:0]       immediate_o,
   output logic [25:0]       target_o,
   output logic [1:0]        fault_o
);

   localparam int unsigned       IdxW     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
   localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(DEPTH_BYTES - 4);
   localparam logic [ADDR_W-1:0] DepthA   = ADDR_W'(DEPTH_BYTES);

   logic [7:0]      mem_q [DEPTH_BYTES];
   logic [IdxW-1:0] pc_idx;
   logic [IdxW-1:0] ld_idx;
   logic            misaligned;
   logic            out_of_range;
   logic [1:0]      fault_code;
   logic [31:0]     rd_word;

   logic        inst_valid_q, inst_valid_d;
   logic [31:0] instr_q, instr_d;
   logic [1:0]  fault_q, fault_d;

   assign ld_idx = ld_addr_i[IdxW-1:0];

   // Memory contents survive reset, so the array has no reset branch.
   always_ff @(posedge clk_i) begin
      if (ld_en_i && (ld_addr_i < DepthA)) begin
         mem_q[ld_idx] <= ld_data_i;
      end
   end

   assign pc_idx       = pc_i[IdxW-1:0];
   assign misaligned   = |pc_i[1:0];
   assign out_of_range = pc_i > LastWord;
   assign fault_code   = misaligned ? 2'b01 : (out_of_range ? 2'b10 : 2'b00);

   // Only index the array for an aligned in-range pc, so no read falls past the end.
   always_comb begin
      rd_word = '0;
      if (fault_code == 2'b00) begin
         rd_word = {mem_q[pc_idx], mem_q[pc_idx + IdxW'(1)],
                    mem_q[pc_idx + IdxW'(2)], mem_q[pc_idx + IdxW'(3)]};
      end
   end

   always_comb begin
      inst_valid_d = inst_valid_q;
      instr_d      = instr_q;
      fault_d      = fault_q;
      if (!stall_i) begin
         if (ld_en_i) begin
            inst_valid_d = 1'b0;
         end else begin
            inst_valid_d = fetch_req_i;
            if (fetch_req_i) begin
               instr_d = rd_word;
               fault_d = fault_code;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inst_valid_q <= 1'b0;
         instr_q      <= '0;
         fault_q      <= 2'b00;
      end else begin
         inst_valid_q <= inst_valid_d;
         instr_q      <= instr_d;
         fault_q      <= fault_d;
      end
   end

   assign inst_valid_o = inst_valid_q;
   assign instr_o      = instr_q;
   assign fault_o      = fault_q;
   assign op_o         = instr_q[31:26];
   assign rs_o         = instr_q[25:21];
   assign rt_o         = instr_q[20:16];
   assign rd_o         = instr_q[15:11];
   assign shamt_o      = instr_q[10:6];
   assign funct_o      = instr_q[5:0];
   assign immediate_o  = instr_q[15:0];
   assign target_o     = instr_q[25:0];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: a byte-array reference model queues the expected
// output state after every edge; a negedge monitor pops and compares.
module tb_instr_fetch_mem;

   localparam int unsigned Depth = 128;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, stall, ld_en;
   logic [31:0] pc, ld_addr;
   logic [7:0]  ld_data;
   logic        inst_valid;
   logic [31:0] instr;
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] immediate;
   logic [25:0] target;
   logic [1:0]  fault;

   typedef struct packed {
      logic        v;
      logic [31:0] i;
      logic [1:0]  f;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] m [Depth];
   logic       mv = 1'b0;
   logic [31:0] mi = '0;
   logic [1:0] mf = 2'b00;

   instr_fetch_mem #(
      .DEPTH_BYTES(Depth),
      .ADDR_W     (32),
      .INIT_FILE  ("")
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .fetch_req_i (fetch_req),
      .pc_i        (pc),
      .stall_i     (stall),
      .ld_en_i     (ld_en),
      .ld_addr_i   (ld_addr),
      .ld_data_i   (ld_data),
      .inst_valid_o(inst_valid),
      .instr_o     (instr),
      .op_o        (op),
      .rs_o        (rs),
      .rt_o        (rt),
      .rd_o        (rd),
      .shamt_o     (shamt),
      .funct_o     (funct),
      .immediate_o (immediate),
      .target_o    (target),
      .fault_o     (fault)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endfunction

   // Monitor: every cycle the model queued an expected state; compare it at negedge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("valid", 64'(inst_valid), 64'(e.v));
         chk("instr", 64'(instr), 64'(e.i));
         chk("fault", 64'(fault), 64'(e.f));
         chk("fields", 64'({op, rs, rt, rd, shamt, funct}), 64'(e.i));
         chk("imm", 64'(immediate), 64'(e.i[15:0]));
         chk("target", 64'(target), 64'(e.i[25:0]));
      end else if (rst_n && inst_valid) begin
         chk("unexpected_valid", 64'(inst_valid), 64'(0));
      end
   end

   // Drive one edge, then advance the reference model from the rules of the memory.
   task automatic step(input logic req, input logic [31:0] p, input logic st, input logic le,
                       input logic [31:0] la, input logic [7:0] ld);
      fetch_req = req; pc = p; stall = st; ld_en = le; ld_addr = la; ld_data = ld;
      @(posedge clk);
      #1;
      if (!st) begin
         if (le) mv = 1'b0;
         else begin
            mv = req;
            if (req) begin
               if (p[1:0] != 2'b00) begin
                  mi = '0; mf = 2'b01;
               end else if (p > Depth - 4) begin
                  mi = '0; mf = 2'b10;
               end else begin
                  mi = {m[p], m[p+1], m[p+2], m[p+3]}; mf = 2'b00;
               end
            end
         end
      end
      if (le && la < Depth) m[la] = ld;
      q.push_back({mv, mi, mf});
   endtask

   task automatic check_zero(input string name);
      chk({name, "_valid"}, 64'(inst_valid), 64'(0));
      chk({name, "_instr"}, 64'(instr), 64'(0));
      chk({name, "_fault"}, 64'(fault), 64'(0));
      chk({name, "_fields"}, 64'({op, rs, rt, rd, shamt, funct, immediate, target}), 64'(0));
   endtask

   initial begin
      logic [31:0] bnd [6];
      logic [31:0] p;
      int          r;
      bnd[0] = 120; bnd[1] = 124; bnd[2] = 126; bnd[3] = 128; bnd[4] = 130; bnd[5] = 132;
      rst_n = 1'b0; fetch_req = 0; pc = 0; stall = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
      #12;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < Depth; i++) step(0, 0, 0, 1, i, 8'($urandom));
      step(0, 0, 0, 1, 0, 8'h8C); step(0, 0, 0, 1, 1, 8'h22);
      step(0, 0, 0, 1, 2, 8'h00); step(0, 0, 0, 1, 3, 8'h04);

      // Basic fetch of a lw word
      step(1, 0, 0, 0, 0, 0);
      chk("t1_instr", 64'(instr), 64'h8C22_0004);
      chk("t1_op", 64'(op), 64'h23);
      chk("t1_rs_rt", 64'({rs, rt}), 64'({5'd1, 5'd2}));
      chk("t1_imm", 64'(immediate), 64'h0004);
      chk("t1_vf", 64'({inst_valid, fault}), 64'({1'b1, 2'b00}));

      // Stall hold, then release
      for (int i = 0; i < 3; i++) begin
         step(1, 4, 1, 0, 0, 0);
         chk("t2_hold", 64'({inst_valid, instr}), 64'({1'b1, 32'h8C22_0004}));
      end
      step(1, 4, 0, 0, 0, 0);

      // Fault boundaries
      step(1, 2, 0, 0, 0, 0);
      chk("t3_mis", 64'({inst_valid, instr, fault}), 64'({1'b1, 32'h0, 2'b01}));
      step(1, Depth - 4, 0, 0, 0, 0);
      chk("t3_last", 64'(fault), 64'(2'b00));
      step(1, Depth, 0, 0, 0, 0);
      chk("t3_oor", 64'({inst_valid, instr, fault}), 64'({1'b1, 32'h0, 2'b10}));
      step(1, Depth + 2, 0, 0, 0, 0);
      chk("t3_both", 64'(fault), 64'(2'b01));

      // Program load then fetch; load beats a same-edge fetch
      step(0, 0, 0, 1, 16, 8'h00); step(0, 0, 0, 1, 17, 8'h43);
      step(0, 0, 0, 1, 18, 8'h20); step(0, 0, 0, 1, 19, 8'h20);
      step(1, 16, 0, 0, 0, 0);
      chk("t4_instr", 64'(instr), 64'h0043_2020);
      chk("t4_funct_rd", 64'({funct, rd}), 64'({6'h20, 5'd4}));
      step(1, 16, 0, 1, 40, 8'h5A);
      chk("t4_ld_prio", 64'(inst_valid), 64'(0));

      // Asynchronous reset between edges
      step(1, 0, 0, 0, 0, 0);
      #6;
      rst_n = 1'b0;
      #1;
      check_zero("t5_rst");
      mv = 1'b0; mi = '0; mf = 2'b00;
      fetch_req = 0; ld_en = 0; stall = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, 0, 0, 0, 0);
      chk("t5_refetch", 64'(instr), 64'h8C22_0004);

      // Out-of-range load is ignored
      step(0, 0, 0, 1, Depth, 8'hFF);
      step(1, Depth - 4, 0, 0, 0, 0);
      chk("t6_last_word", 64'(instr), 64'({m[Depth-4], m[Depth-3], m[Depth-2], m[Depth-1]}));

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 9);
         if (r <= 4 || r >= 8) p = 32'(4 * $urandom_range(0, Depth / 4 - 1));
         else if (r == 5) p = 32'($urandom_range(0, Depth + 3));
         else if (r == 6) p = bnd[$urandom_range(0, 5)];
         else p = $urandom();
         step(($urandom_range(0, 9) < 7), p, ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 6) == 0),
              ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, Depth - 1)),
              8'($urandom));
      end

      #6;
      chk("drain", 64'(q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
